// File: rtl/lane_deskew_ctrl.sv
// JESD204B RX lane deskew controller: waits for all enabled lanes, scans latencies,
// computes per-lane release delays. Optional relock on ready loss: LANE_DESKEW_RELOCK_EN.
module lane_deskew_ctrl #(
  parameter int unsigned L               = 1,
  parameter int unsigned PARALLEL_OCTETS = 4,
  parameter int unsigned MAX_SKEW        = 16,
  parameter int unsigned TIMEOUT         = 2047,
  parameter int unsigned DLY_W           = $clog2(MAX_SKEW + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [L*14-1:0]    lane_latency_i,
  input  logic [L-1:0]       lane_latency_ready_i,
  input  logic [L-1:0]       lane_enable_i,
  input  logic               restart_i,
  output logic [L*DLY_W-1:0] lane_delay_o,
  output logic [L*3-1:0]     lane_octet_shift_o,
  output logic [10:0]        max_skew_o,
  output logic               release_o,
  output logic               aligned_o,
  output logic               skew_err_o,
`ifdef LANE_DESKEW_RELOCK_EN
  output logic [7:0]         relock_cnt_o,
`endif
  output logic               timeout_err_o
);

  localparam int unsigned IdxW    = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(L - 1);
  localparam logic [10:0]     SkewMax = 11'(MAX_SKEW);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
  if (PARALLEL_OCTETS < 1) begin : g_bad_octets
    $error("PARALLEL_OCTETS must be at least 1");
  end

  typedef enum logic [2:0] {StWaitAll, StScan, StCheck, StAligned, StError} state_e;

  state_e          state_q;
  logic [TmoW-1:0] tmo_q;
  logic [IdxW-1:0] idx_q;
  logic [L-1:0]    en_q;
  logic [10:0]     max_q, min_q;
  logic            seen_q;

  logic        all_ready;
  logic        ready_drop;
  logic [10:0] cur_beat;
  logic [10:0] spread;

  assign all_ready  = ((lane_latency_ready_i & lane_enable_i) == lane_enable_i) &&
                      (lane_enable_i != '0);
  assign ready_drop = (lane_latency_ready_i & en_q) != en_q;
  assign cur_beat   = lane_latency_i[idx_q*14+3 +: 11];
  assign spread     = max_q - min_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q            <= StWaitAll;
      tmo_q              <= '0;
      idx_q              <= '0;
      en_q               <= '0;
      max_q              <= '0;
      min_q              <= '0;
      seen_q             <= 1'b0;
      lane_delay_o       <= '0;
      lane_octet_shift_o <= '0;
      max_skew_o         <= '0;
      release_o          <= 1'b0;
      aligned_o          <= 1'b0;
      skew_err_o         <= 1'b0;
      timeout_err_o      <= 1'b0;
`ifdef LANE_DESKEW_RELOCK_EN
      relock_cnt_o       <= '0;
`endif
    end else if (restart_i) begin
      state_q            <= StWaitAll;
      tmo_q              <= '0;
      lane_delay_o       <= '0;
      lane_octet_shift_o <= '0;
      max_skew_o         <= '0;
      release_o          <= 1'b0;
      aligned_o          <= 1'b0;
      skew_err_o         <= 1'b0;
      timeout_err_o      <= 1'b0;
    end else begin
      unique case (state_q)
        StWaitAll: begin
          if (lane_enable_i == '0) begin
            tmo_q <= '0;
          end else if (tmo_q != TmoMax) begin
            tmo_q <= tmo_q + TmoW'(1);
          end
          if (all_ready) begin
            en_q    <= lane_enable_i;
            idx_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
            seen_q  <= 1'b0;
            tmo_q   <= '0;
            state_q <= StScan;
          end else if ((lane_enable_i != '0) && (tmo_q == TmoMax)) begin
            timeout_err_o <= 1'b1;
            state_q       <= StError;
          end
        end
        StScan: begin
          if (ready_drop) begin
            tmo_q   <= '0;
            state_q <= StWaitAll;
          end else begin
            // The first enabled lane seeds both extremes.
            if (en_q[idx_q]) begin
              if (!seen_q || (cur_beat > max_q)) max_q <= cur_beat;
              if (!seen_q || (cur_beat < min_q)) min_q <= cur_beat;
              seen_q <= 1'b1;
            end
            if (idx_q == IdxLast) begin
              state_q <= StCheck;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        StCheck: begin
          max_skew_o <= spread;
          if (spread > SkewMax) begin
            skew_err_o <= 1'b1;
            state_q    <= StError;
          end else begin
            for (int i = 0; i < L; i++) begin
              lane_delay_o[i*DLY_W +: DLY_W] <=
                en_q[i] ? DLY_W'(max_q - lane_latency_i[i*14+3 +: 11]) : '0;
              lane_octet_shift_o[i*3 +: 3] <= lane_latency_i[i*14 +: 3];
            end
            release_o <= 1'b1;
            aligned_o <= 1'b1;
            state_q   <= StAligned;
          end
        end
        StAligned: begin
`ifdef LANE_DESKEW_RELOCK_EN
          if (ready_drop) begin
            state_q            <= StWaitAll;
            tmo_q              <= '0;
            release_o          <= 1'b0;
            aligned_o          <= 1'b0;
            lane_delay_o       <= '0;
            lane_octet_shift_o <= '0;
            max_skew_o         <= '0;
            if (relock_cnt_o != 8'hFF) relock_cnt_o <= relock_cnt_o + 8'd1;
          end
`endif
        end
        StError: begin
          release_o <= 1'b0;
          aligned_o <= 1'b0;
        end
        default: state_q <= StWaitAll;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_deskew_ctrl.sv
// Directed bench for lane_deskew_ctrl: a 4-lane instance (TIMEOUT=10) and a 2-lane instance.
module tb_lane_deskew_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: L=4, TIMEOUT=10
  logic [55:0] a_lat;
  logic [3:0]  a_rdy, a_en;
  logic        a_rst;
  logic [19:0] a_dly;
  logic [11:0] a_sh;
  logic [10:0] a_ms;
  logic        a_rel, a_al, a_se, a_te;

  // Instance B: L=2, default TIMEOUT
  logic [27:0] b_lat;
  logic [1:0]  b_rdy, b_en;
  logic        b_rst;
  logic [9:0]  b_dly;
  logic [5:0]  b_sh;
  logic [10:0] b_ms;
  logic        b_rel, b_al, b_se, b_te;

`ifdef LANE_DESKEW_RELOCK_EN
  logic [7:0] a_rc, b_rc;
`endif

  lane_deskew_ctrl #(.L(4), .PARALLEL_OCTETS(4), .MAX_SKEW(16), .TIMEOUT(10)) dut_a (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .lane_latency_i      (a_lat),
    .lane_latency_ready_i(a_rdy),
    .lane_enable_i       (a_en),
    .restart_i           (a_rst),
    .lane_delay_o        (a_dly),
    .lane_octet_shift_o  (a_sh),
    .max_skew_o          (a_ms),
    .release_o           (a_rel),
    .aligned_o           (a_al),
    .skew_err_o          (a_se),
`ifdef LANE_DESKEW_RELOCK_EN
    .relock_cnt_o        (a_rc),
`endif
    .timeout_err_o       (a_te)
  );

  lane_deskew_ctrl #(.L(2), .PARALLEL_OCTETS(4), .MAX_SKEW(16)) dut_b (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .lane_latency_i      (b_lat),
    .lane_latency_ready_i(b_rdy),
    .lane_enable_i       (b_en),
    .restart_i           (b_rst),
    .lane_delay_o        (b_dly),
    .lane_octet_shift_o  (b_sh),
    .max_skew_o          (b_ms),
    .release_o           (b_rel),
    .aligned_o           (b_al),
    .skew_err_o          (b_se),
`ifdef LANE_DESKEW_RELOCK_EN
    .relock_cnt_o        (b_rc),
`endif
    .timeout_err_o       (b_te)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [13:0] ll(input int beat, input int al);
    return {11'(beat), 3'(al)};
  endfunction

  task automatic restart_a();
    a_rst = 1'b1;
    tick(1);
    a_rst = 1'b0;
    a_en  = 4'h0;
    a_rdy = 4'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_lat = '0; a_rdy = '0; a_en = '0; a_rst = 1'b0;
    b_lat = '0; b_rdy = '0; b_en = '0; b_rst = 1'b0;
    tick(2);
    check("rst_release", {31'd0, a_rel}, 0);
    check("rst_aligned", {31'd0, a_al}, 0);
    check("rst_delay", {12'd0, a_dly}, 0);
    check("rst_errs", {30'd0, a_se, a_te}, 0);
    check("rst_b_skew", {21'd0, b_ms}, 0);
`ifdef LANE_DESKEW_RELOCK_EN
    check("rst_relock", {24'd0, a_rc}, 0);
`endif

    // Timeout: lane 3 never ready, enable present from reset release.
    a_en  = 4'hF;
    a_rdy = 4'b0111;
    rst_n = 1'b1;
    tick(10);
    check("tmo_early", {31'd0, a_te}, 0);
    tick(1);
    check("tmo_err", {31'd0, a_te}, 1);
    check("tmo_norel", {31'd0, a_rel}, 0);
    restart_a();
    check("tmo_cleared", {31'd0, a_te}, 0);
    tick(2);

    // Main alignment: beats 100/103/101/100, aligns 1/2/3/0.
    a_lat = {ll(100, 0), ll(101, 3), ll(103, 2), ll(100, 1)};
    a_en  = 4'hF;
    a_rdy = 4'hF;
    tick(5);
    check("main_rel_early", {31'd0, a_rel}, 0);
    tick(1);
    check("main_rel", {31'd0, a_rel}, 1);
    check("main_aligned", {31'd0, a_al}, 1);
    check("main_delay", {12'd0, a_dly}, {12'd0, 5'd3, 5'd2, 5'd0, 5'd3});
    check("main_shift", {20'd0, a_sh}, {20'd0, 3'd0, 3'd3, 3'd2, 3'd1});
    check("main_skew", {21'd0, a_ms}, 3);
    check("main_noerr", {30'd0, a_se, a_te}, 0);

    a_rdy = 4'b1110;
`ifdef LANE_DESKEW_RELOCK_EN
    tick(1);
    check("relock_rel", {31'd0, a_rel}, 0);
    check("relock_al", {31'd0, a_al}, 0);
    check("relock_cnt", {24'd0, a_rc}, 1);
    check("relock_dly", {12'd0, a_dly}, 0);
    a_rdy = 4'hF;
    tick(6);
    check("relock_again", {31'd0, a_rel}, 1);
    check("relock_dly2", {12'd0, a_dly}, {12'd0, 5'd3, 5'd2, 5'd0, 5'd3});
`else
    tick(3);
    check("hold_rel", {31'd0, a_rel}, 1);
    check("hold_dly", {12'd0, a_dly}, {12'd0, 5'd3, 5'd2, 5'd0, 5'd3});
`endif
    restart_a();
    check("rs_rel", {31'd0, a_rel}, 0);
    check("rs_al", {31'd0, a_al}, 0);
    check("rs_dly", {12'd0, a_dly}, 0);
    check("rs_sh", {20'd0, a_sh}, 0);
    check("rs_ms", {21'd0, a_ms}, 0);
    tick(2);

    // Partial mask 0101: lanes 1 and 3 carry beat 500 and are not ready.
    a_lat = {ll(500, 0), ll(207, 6), ll(500, 0), ll(200, 5)};
    a_en  = 4'b0101;
    a_rdy = 4'b0101;
    tick(6);
    check("mask_rel", {31'd0, a_rel}, 1);
    check("mask_dly", {12'd0, a_dly}, {12'd0, 5'd0, 5'd0, 5'd0, 5'd7});
    check("mask_skew", {21'd0, a_ms}, 7);
    check("mask_shift", {20'd0, a_sh}, {20'd0, 3'd0, 3'd6, 3'd0, 3'd5});
    restart_a();
    tick(2);

    // Ready drop of lane 2 on SCAN cycle 1, then restore.
    a_lat = {ll(51, 0), ll(55, 0), ll(52, 0), ll(50, 0)};
    a_en  = 4'hF;
    a_rdy = 4'hF;
    tick(2);
    a_rdy = 4'b1011;
    tick(4);
    check("drop_rel", {31'd0, a_rel}, 0);
    check("drop_al", {31'd0, a_al}, 0);
    check("drop_noerr", {30'd0, a_se, a_te}, 0);
    a_rdy = 4'hF;
    tick(5);
    check("drop_rel_early", {31'd0, a_rel}, 0);
    tick(1);
    check("drop_realign", {31'd0, a_rel}, 1);
    check("drop_dly", {12'd0, a_dly}, {12'd0, 5'd4, 5'd0, 5'd3, 5'd5});
    check("drop_skew", {21'd0, a_ms}, 5);

    // Two-lane skew error: beats 100 and 120.
    b_lat = {ll(120, 0), ll(100, 0)};
    b_en  = 2'b11;
    b_rdy = 2'b11;
    tick(4);
    check("skew_err", {31'd0, b_se}, 1);
    check("skew_val", {21'd0, b_ms}, 20);
    check("skew_norel", {31'd0, b_rel}, 0);
    tick(2);
    check("skew_hold", {31'd0, b_se}, 1);
    check("skew_norel2", {31'd0, b_rel | b_al}, 0);
    b_rst = 1'b1;
    tick(1);
    b_rst = 1'b0;
    b_en  = 2'b00;
    check("skew_rs_err", {31'd0, b_se}, 0);
    check("skew_rs_ms", {21'd0, b_ms}, 0);
    check("skew_rs_dly", {22'd0, b_dly}, 0);

    // Asynchronous reset while A is aligned.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rel", {31'd0, a_rel}, 0);
    check("async_dly", {12'd0, a_dly}, 0);
    check("async_ms", {21'd0, a_ms}, 0);
    tick(1);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
